// File: rtl/dds_dac_serializer.sv
// Captures DDS samples on each rising edge of ready, buffers them, and shifts them
// MSB-first onto a 3-wire serial DAC port (sclk / din / sync_n).
module dds_dac_serializer #(
   parameter int DATA_W        = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int CLK_DIV       = 2,
   parameter int GAP_CYCLES    = 2,
   parameter int OFFSET_BINARY = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             q,
   input  logic                          ready,
   output logic                          dac_sclk,
   output logic                          dac_din,
   output logic                          dac_sync_n,
   output logic                          frame_done,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   // state | meaning
   // IDLE  | waiting for a buffered sample; pops and starts a frame when one exists
   // SHIFT | frame active, sclk toggling every CLK_DIV cycles, din moves on sclk fall
   // GAP   | sync_n held high for GAP_CYCLES before the next frame may start

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int BW = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] XMASK = {(OFFSET_BINARY != 0), {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              ready_d;
   logic              push;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] shreg;
   logic [DW-1:0]     div_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [BW-1:0]     bit_cnt;
   state_t            state;

   assign push  = ready & ~ready_d;
   assign full  = (fifo_level == LW'(FIFO_DEPTH));
   assign pop   = (state == IDLE) && (fifo_level != '0);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign wr_en = push && (!full || pop);
   assign head  = mem[rd_ptr] ^ XMASK;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_d    <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         ready_d <= ready;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)      fifo_level <= fifo_level + LW'(1);
         else if (!wr_en && pop) fifo_level <= fifo_level - LW'(1);
         if (push && !wr_en) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         dac_sclk   <= 1'b0;
         dac_din    <= 1'b0;
         dac_sync_n <= 1'b1;
         frame_done <= 1'b0;
         shreg      <= '0;
         div_cnt    <= '0;
         gap_cnt    <= '0;
         bit_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg      <= head << 1;
                  dac_din    <= head[DATA_W-1];
                  dac_sync_n <= 1'b0;
                  dac_sclk   <= 1'b0;
                  div_cnt    <= '0;
                  bit_cnt    <= BW'(DATA_W-1);
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt == DW'(CLK_DIV-1)) begin
                  div_cnt  <= '0;
                  dac_sclk <= ~dac_sclk;
                  if (dac_sclk) begin
                     // falling toggle: present the next bit, or close the frame after the last
                     if (bit_cnt == '0) begin
                        state      <= GAP;
                        dac_sync_n <= 1'b1;
                        frame_done <= 1'b1;
                        dac_din    <= 1'b0;
                        gap_cnt    <= GW'(GAP_CYCLES-1);
                     end else begin
                        dac_din <= shreg[DATA_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - BW'(1);
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - GW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_dac_serializer.sv
// Bench for dds_dac_serializer: two instances (default timing and CLK_DIV=1/GAP=1)
// checked cycle by cycle against a timing/queue model and a serial-word decoder.
module tb_dds_dac_serializer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ready_s = 1'b0;
   logic        sel = 1'b0;
   logic [15:0] q = '0;

   logic        ready0, ready1;
   logic        sclk0, din0, sync0, fd0, ovf0;
   logic        sclk1, din1, sync1, fd1, ovf1;
   logic [2:0]  lvl0, lvl1;

   assign ready0 = ready_s & ~sel;
   assign ready1 = ready_s & sel;

   dds_dac_serializer #(.CLK_DIV(2), .GAP_CYCLES(2)) u_dut0 (
      .clk(clk), .reset(reset), .q(q), .ready(ready0),
      .dac_sclk(sclk0), .dac_din(din0), .dac_sync_n(sync0),
      .frame_done(fd0), .overflow(ovf0), .fifo_level(lvl0)
   );

   dds_dac_serializer #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset), .q(q), .ready(ready1),
      .dac_sclk(sclk1), .dac_din(din1), .dac_sync_n(sync1),
      .frame_done(fd1), .overflow(ovf1), .fifo_level(lvl1)
   );

   always #5 clk = ~clk;

   logic       m_sclk, m_din, m_sync, m_fd, m_ovf_dut;
   logic [2:0] m_lvl;
   int         cdiv, gapc;
   assign m_sclk    = sel ? sclk1 : sclk0;
   assign m_din     = sel ? din1  : din0;
   assign m_sync    = sel ? sync1 : sync0;
   assign m_fd      = sel ? fd1   : fd0;
   assign m_ovf_dut = sel ? ovf1  : ovf0;
   assign m_lvl     = sel ? lvl1  : lvl0;
   assign cdiv      = sel ? 1 : 2;
   assign gapc      = sel ? 1 : 2;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference model: FIFO as a queue, frame timing from the frame-period arithmetic
   int          cyc = 0;
   int          last_pop = -1000000;
   logic [15:0] mq[$];
   logic [15:0] exp_words[$];
   bit          m_rd = 1'b1;
   bit          m_ovf = 1'b0;
   bit          push_m;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         mq.delete();
         exp_words.delete();
         last_pop = -1000000;
         m_rd     = 1'b1;
         m_ovf    = 1'b0;
      end else begin
         push_m = ready_s && !m_rd;
         m_rd   = ready_s;
         if (mq.size() > 0 && cyc >= last_pop + 1 + 32*cdiv + gapc) begin
            exp_words.push_back(mq.pop_front() ^ 16'h8000);
            last_pop = cyc;
         end
         if (push_m) begin
            if (mq.size() < DEPTH) mq.push_back(q);
            else                   m_ovf = 1'b1;
         end
      end
   end

   // per-cycle output checks and serial decoder, sampled on the falling clock edge
   int          t;
   bit          in_shift;
   bit          p_sclk = 1'b0, p_din = 1'b0, p_sync = 1'b1;
   int          bits = 0;
   int          last_rise = 0;
   int          high_cnt = 0;
   int          last_gap = 0;
   int          nframes = 0;
   logic [15:0] word = '0;
   logic [15:0] last_word = '0;
   logic [15:0] prev_word = '0;
   logic [15:0] dec_log[$];

   always @(negedge clk) begin
      t        = cyc - last_pop;
      in_shift = (t >= 0) && (t < 32*cdiv);
      check("sync_n",     m_sync,    !in_shift);
      check("sclk",       m_sclk,    in_shift ? ((t / cdiv) % 2) : 0);
      check("frame_done", m_fd,      t == 32*cdiv);
      check("fifo_level", m_lvl,     mq.size());
      check("overflow",   m_ovf_dut, m_ovf);
      if (reset) begin
         bits = 0;
      end else begin
         if (m_sclk) check("din_hold", m_din, p_din);
         if (m_sclk && !p_sclk && !m_sync) begin
            word = {word[14:0], m_din};
            if (bits > 0) check("sclk_period", cyc - last_rise, 2*cdiv);
            last_rise = cyc;
            bits++;
         end
         if (m_sync && !p_sync) begin
            check("frame_bits", bits, 16);
            check("frame_pending", exp_words.size() > 0, 1);
            if (exp_words.size() > 0) check("frame_word", word, exp_words.pop_front());
            prev_word = last_word;
            last_word = word;
            dec_log.push_back(word);
            nframes++;
            bits     = 0;
            high_cnt = 0;
         end
         if (!m_sync && p_sync) last_gap = high_cnt;
         if (m_sync) high_cnt++;
      end
      p_sclk = m_sclk;
      p_din  = m_din;
      p_sync = m_sync;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [15:0] v);
      q       = v;
      ready_s = 1'b1;
      tick(1);
      ready_s = 1'b0;
   endtask

   int          nf0, base;
   bit          hit;
   logic [15:0] sent[6];

   initial begin
      tick(3);
      check("rst_sync",  sync0, 1);
      check("rst_sclk",  sclk0, 0);
      check("rst_din",   din0,  0);
      check("rst_level", lvl0,  0);
      reset = 1'b0;
      tick(2);

      // single sample, latency and offset-binary transform
      q = 16'h0000;
      ready_s = 1'b1;
      tick(1);
      check("t1_sync_pre", sync0, 1);
      ready_s = 1'b0;
      tick(1);
      check("t1_latency", sync0, 0);
      tick(80);
      check("t1_word",   last_word, 16'h8000);
      check("t1_level",  lvl0, 0);
      check("t1_frames", nframes, 1);

      // back-to-back frames
      pulse(16'h7FFF);
      tick(9);
      pulse(16'h8001);
      tick(150);
      check("t2_word0", prev_word, 16'hFFFF);
      check("t2_word1", last_word, 16'h0001);
      check("t2_gap",   last_gap, 3);

      // overflow: 6 pushes, one in flight plus four buffered
      base = dec_log.size();
      for (int i = 0; i < 6; i++) begin
         sent[i] = 16'($urandom);
         pulse(sent[i]);
         tick(2);
      end
      check("t3_ovf", ovf0, 1);
      tick(400);
      check("t3_count", dec_log.size() - base, 5);
      for (int i = 0; i < 5; i++)
         if (dec_log.size() > base + i) check("t3_order", dec_log[base+i], sent[i] ^ 16'h8000);
      check("t3_ovf_sticky", ovf0, 1);

      // reset mid-frame at the 8th sclk rising edge
      pulse(16'($urandom));
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         tick(1);
         if (bits == 8) hit = 1'b1;
      end
      check("t4_reached", hit, 1);
      reset = 1'b1;
      tick(1);
      check("t4_sync",  sync0, 1);
      check("t4_sclk",  sclk0, 0);
      check("t4_level", lvl0,  0);
      reset = 1'b0;
      nf0 = nframes;
      tick(200);
      check("t4_no_frame", nframes - nf0, 0);
      check("t4_ovf_clr", ovf0, 0);

      // ready held high through reset release is not a sample
      reset   = 1'b1;
      ready_s = 1'b1;
      tick(2);
      reset = 1'b0;
      nf0 = nframes;
      tick(100);
      check("t5_no_frame", nframes - nf0, 0);
      check("t5_level", lvl0, 0);
      ready_s = 1'b0;
      tick(1);
      pulse(16'h1234);
      tick(80);
      check("t5_word", last_word, 16'h9234);

      // random ready toggling with random data
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 11) == 0) ready_s = ~ready_s;
         q = 16'($urandom);
         tick(1);
      end
      ready_s = 1'b0;
      tick(400);

      // switch to the fast instance
      reset = 1'b1;
      tick(1);
      sel = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);
      base = dec_log.size();
      for (int i = 0; i < 20; i++) begin
         pulse(16'(i * 16'h0101));
         tick(33);
      end
      tick(60);
      check("t6_count", dec_log.size() - base, 20);
      for (int i = 0; i < 20; i++)
         if (dec_log.size() > base + i) check("t6_word", dec_log[base+i], 16'(i * 16'h0101) ^ 16'h8000);
      check("t6_ovf", ovf1, 0);
      check("t6_gap", last_gap, 2);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) ready_s = ~ready_s;
         q = 16'($urandom);
         tick(1);
      end
      ready_s = 1'b0;
      tick(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
